stage3_writeback: RTL

- Final execution stage of the QLifeProcessor core; sits directly downstream of STAGE2.
- Consumes STAGE2 results (vw_value, ram_address, alu_is_zero) plus the stage-3 control field mblock_s3 from decode.
- Performs the writeback, owns the architectural PC, and signals retirement.
- The writeback is a RAM write, an IO output latch, a branch/jump, or a halt; RAM writes complete over a valid/ack handshake.

---
 rtl/stage3_writeback_pkg.sv | 25 ++
 rtl/stage3_writeback_pc_next_logic.sv | 29 ++
 rtl/stage3_writeback.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/stage3_writeback_pkg.sv
// stage_defs: shared definitions for the stage-3 writeback slice.
// Holds writeback opcodes, FSM state encodings and datapath widths.
package stage_defs;

    localparam int PC_W   = 16;
    localparam int DATA_W = 32;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_NOP    = 3'd0;
    localparam logic [OP_W-1:0] OP_RAM_WR = 3'd1;
    localparam logic [OP_W-1:0] OP_IO_OUT = 3'd2;
    localparam logic [OP_W-1:0] OP_JMP    = 3'd3;
    localparam logic [OP_W-1:0] OP_JZ     = 3'd4;
    localparam logic [OP_W-1:0] OP_JNZ    = 3'd5;
    localparam logic [OP_W-1:0] OP_HALT   = 3'd6;
    localparam logic [OP_W-1:0] OP_RSVD   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MEMWR  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

endpackage

// File: rtl/stage3_writeback_pc_next_logic.sv
// pc_next_logic: combinational next-PC selection for the writeback stage.
// Taken jumps load the low PC_W bits of the target, else PC advances by PC_STEP.
module pc_next_logic
    import stage_defs::*;
#(
    parameter logic [PC_W-1:0] PC_STEP = 16'd4
) (
    input  logic [OP_W-1:0] op,
    input  logic            alu_is_zero,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] next_pc
);

    logic taken;

    // Decide whether the op redirects the PC, then pick target or sequential PC
    always_comb begin
        taken = 1'b0;
        case (op)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = alu_is_zero;
            OP_JNZ:  taken = ~alu_is_zero;
            default: taken = 1'b0;
        endcase
        next_pc = taken ? target : pc + PC_STEP;
    end

endmodule

// File: rtl/stage3_writeback.sv
// stage3_writeback: final core stage; RAM write, IO latch, branch, halt, retire.
// Optional macro STAGE3_RETIRE_COUNTER_EN adds retired_count and count_clear.
module stage3_writeback
    import stage_defs::*;
#(
    parameter logic [PC_W-1:0] PC_RESET = 16'd0,
    parameter logic [PC_W-1:0] PC_STEP  = 16'd4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   mblock_s3,
    input  logic [DATA_W-1:0] vw_value,
    input  logic [PC_W-1:0]   ram_address,
    input  logic              alu_is_zero,
    output logic [PC_W-1:0]   pc,
    output logic              ram_we,
    output logic [PC_W-1:0]   ram_wr_address,
    output logic [DATA_W-1:0] ram_wr_value,
    input  logic              ram_wr_ack,
    output logic [DATA_W-1:0] io_out,
`ifdef STAGE3_RETIRE_COUNTER_EN
    output logic [31:0]       retired_count,
    input  logic              count_clear,
`endif
    output logic              retire,
    output logic              halted
);

    state_t state;
    state_t state_nxt;

    logic [OP_W-1:0]   cap_op;
    logic [DATA_W-1:0] cap_val;
    logic              cap_zero;
    logic              xfer;
    logic [PC_W-1:0]   pc_nxt;

    assign xfer = in_valid & in_ready;

    pc_next_logic #(
        .PC_STEP (PC_STEP)
    ) u_pc_next (
        .op          (cap_op),
        .alu_is_zero (cap_zero),
        .pc          (pc),
        .target      (cap_val[PC_W-1:0]),
        .next_pc     (pc_nxt)
    );

    // State register; reset abandons any pending write at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept in IDLE, wait for ack in MEMWR, one-cycle COMMIT
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (xfer) begin
                    if (mblock_s3 == OP_RAM_WR) begin
                        state_nxt = ST_MEMWR;
                    end else begin
                        state_nxt = ST_COMMIT;
                    end
                end
            end
            ST_MEMWR: begin
                if (ram_wr_ack) begin
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (cap_op == OP_HALT) begin
                    state_nxt = ST_HALT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded purely from state so they follow async reset immediately
    always_comb begin
        in_ready = 1'b0;
        ram_we   = 1'b0;
        retire   = 1'b0;
        halted   = 1'b0;
        unique case (state)
            ST_IDLE:   in_ready = 1'b1;
            ST_MEMWR:  ram_we   = 1'b1;
            ST_COMMIT: retire   = 1'b1;
            ST_HALT:   halted   = 1'b1;
            default:   in_ready = 1'b0;
        endcase
    end

    // Capture the transaction so STAGE2 is free to change after the accept edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_op         <= OP_NOP;
            cap_val        <= '0;
            cap_zero       <= 1'b0;
            ram_wr_address <= '0;
            ram_wr_value   <= '0;
        end else if (xfer) begin
            cap_op   <= mblock_s3;
            cap_val  <= vw_value;
            cap_zero <= alu_is_zero;
            if (mblock_s3 == OP_RAM_WR) begin
                ram_wr_address <= ram_address;
                ram_wr_value   <= vw_value;
            end
        end
    end

    // Architectural effects land at the end of COMMIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= PC_RESET;
            io_out <= '0;
        end else if (state == ST_COMMIT) begin
            pc <= pc_nxt;
            if (cap_op == OP_IO_OUT) begin
                io_out <= cap_val;
            end
        end
    end

`ifdef STAGE3_RETIRE_COUNTER_EN
    // Retire counter; a clear wins over a coincident retire
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_count <= '0;
        end else if (count_clear) begin
            retired_count <= '0;
        end else if (retire) begin
            retired_count <= retired_count + 32'd1;
        end
    end
`endif

endmodule
